aes_stream_ctrl: RTL and testbench
==================================

AES_STREAM_CTRL -- requirements
Module: aes_stream_ctrl

Interface
REQ-001 SHALL have parameter: WDT_CYCLES, 4096, ISSUE-state cycle limit before abort (used only under REQ-030).
REQ-002 SHALL have port: clk  in  1  single clock, all logic rising-edge.
REQ-003 SHALL have port: rst  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have ports: s_valid in 1 / s_ready out 1 / s_data in 128 / s_first in 1 (message start) / s_key in 128 / s_enc_dec in 1 (1=encrypt) / s_mode in 1 (1=CBC, 0=ECB).
REQ-005 SHALL have ports: m_valid out 1 / m_ready in 1 / m_data out 128 / m_first out 1 (result of a message's first block).
REQ-006 SHALL have core-side ports: core_init out 1 / core_next out 1 / core_enc_dec out 1 / core_mode out 1 / core_key out 128 / core_block_in out 128 / core_block_out in 128 / core_valid in 1.
REQ-007 SHALL have status ports: busy out 1 / blk_cnt out 16 (blocks completed in current message) / err out 1.

Function
REQ-008 SHALL implement FSM states IDLE, ISSUE, OUT, plus ERR when REQ-030 is enabled.
REQ-009 SHALL drive s_ready=1 only in IDLE; a transfer occurs on a clock edge with s_valid & s_ready.
REQ-010 On transfer: register s_data into core_block_in; move to ISSUE; assert core_init if s_first=1 or key_loaded=0, else core_next. Do not assert core_init and core_next together.
REQ-011 On a transfer that asserts core_init: latch s_key, s_enc_dec and s_mode into core_key, core_enc_dec and core_mode; clear blk_cnt; set key_loaded. Ignore these inputs on transfers that assert core_next.
REQ-012 In ISSUE: hold core_init or core_next, core_block_in, core_key, core_enc_dec and core_mode stable every cycle until the edge where core_valid=1. The core applies CBC chaining combinationally while the request is held.
REQ-013 At the edge with core_valid=1 in ISSUE: capture core_block_out into m_data; deassert core_init/core_next at that same edge; go to OUT; m_first = whether the request was init.
REQ-014 Ignore core_valid outside ISSUE.
REQ-015 In OUT: m_valid=1 and m_data/m_first stable until m_ready=1. At that edge: blk_cnt increments, wrapping 0xFFFF->0x0000; return to IDLE.
REQ-016 Latency: request visible the cycle after transfer; m_valid the cycle after core_valid; next s_ready the cycle after m_ready handshake.
REQ-017 busy = (state != IDLE).
REQ-018 m_ready high before m_valid SHALL have no effect.
REQ-019 s_first=1 mid-message SHALL restart chaining via core_init with the new key/config.

Reset
REQ-020 On rst assertion, asynchronously: state=IDLE, key_loaded=0, core_init=0, core_next=0, m_valid=0, m_first=0, m_data=0, core_block_in=0, core_key=0, core_enc_dec=0, core_mode=0, blk_cnt=0, err=0.
REQ-021 With rst asserted: s_ready=0, busy=0.
REQ-022 Reset during ISSUE or OUT SHALL drop the block silently; the first block after reset always uses core_init.

Configuration
REQ-030 Macro AES_STREAM_CTRL_WDT_EN, when defined: a cycle counter runs in ISSUE. If WDT_CYCLES cycles pass without core_valid, drop core_init/core_next, clear key_loaded, enter ERR. ERR holds err=1, s_ready=0, busy=1 until rst.
REQ-031 Macro AES_STREAM_CTRL_WDT_EN, when undefined: no counter, no ERR state, err tied 0, ISSUE waits indefinitely.

Structure
REQ-040 Package aes_stream_pkg SHALL hold: state enum typedef, localparam AES_BLK_W=128, localparam AES_CNT_W=16.
REQ-041 Sub-module aes_stream_wdt (counter + expiry flag) SHALL be instantiated only under AES_STREAM_CTRL_WDT_EN.

Verification
REQ-050 Reset, then ECB encrypt: s_first=1, key 000102030405060708090a0b0c0d0e0f, data 00112233445566778899aabbccddeeff -> core_init pulse held to core_valid, m_data=69c4e0d86a7b0430d8cdb78070b4c55a, m_first=1, blk_cnt=1.
REQ-051 CBC 3-block message, m_ready always 1 -> init, next, next issued; each m_data matches a reference CBC model with IV=1; blk_cnt=3; s_ready low while busy.
REQ-052 ECB decrypt of 69c4e0d86a7b0430d8cdb78070b4c55a with m_ready held low 10 cycles -> m_valid and m_data stable; m_data=00112233445566778899aabbccddeeff after handshake.
REQ-053 rst asserted mid-ISSUE, then s_first=0 transfer -> outputs cleared at once; core_init (not core_next) used.
REQ-054 With AES_STREAM_CTRL_WDT_EN and WDT_CYCLES=16, core_valid never asserted -> err=1 after 16 ISSUE cycles, core_init=0, s_ready=0 until rst.
REQ-055 blk_cnt preloaded via 65535 completed blocks, one more -> blk_cnt=0x0000.

Source files
------------

// File: rtl/aes_stream_ctrl_pkg.sv
// aes_stream_pkg -- shared types and widths for the AES stream controller.
// Contents:
//   AES_BLK_W  AES block/key width in bits
//   AES_CNT_W  completed-block counter width
//   state_t    controller FSM state encoding (ERR exists only when
//              AES_STREAM_CTRL_WDT_EN is defined)
package aes_stream_pkg;

  localparam int unsigned AES_BLK_W = 128;
  localparam int unsigned AES_CNT_W = 16;

`ifdef AES_STREAM_CTRL_WDT_EN
  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    OUT,
    ERR
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    OUT
  } state_t;
`endif

endpackage

// File: rtl/aes_stream_ctrl_wdt.sv
// aes_stream_wdt -- cycle counter that flags a request the core never answers.
// Ports:
//   clk      clock
//   rst      asynchronous active-high reset
//   run      high while a core request is outstanding; low clears the count
//   expired  high during the WDT_CYCLES-th consecutive run cycle
module aes_stream_wdt #(
  parameter int unsigned WDT_CYCLES = 4096
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic expired
);

  logic [31:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (run) begin
      cnt <= cnt + 32'd1;
    end else begin
      cnt <= '0;
    end
  end

  // cnt is 0 in the first run cycle, so this fires on the last allowed one.
  assign expired = run && (cnt == WDT_CYCLES - 1);

endmodule

// File: rtl/aes_stream_ctrl.sv
// aes_stream_ctrl -- moves blocks from a valid/ready input stream through an
// external AES core and out on a valid/ready result stream, one at a time.
// Ports:
//   clk, rst                clock, asynchronous active-high reset
//   s_valid/s_ready         input handshake (ready only when idle)
//   s_data, s_first         input block, message-start marker
//   s_key, s_enc_dec, s_mode  key / direction (1=enc) / mode (1=CBC),
//                           sampled only on message start
//   m_valid/m_ready         result handshake
//   m_data, m_first         result block, result-of-first-block flag
//   core_init/core_next     held request to the core until core_valid
//   core_enc_dec, core_mode, core_key, core_block_in   request payload
//   core_block_out, core_valid                          core response
//   busy, blk_cnt, err      status
// Optional: AES_STREAM_CTRL_WDT_EN adds a WDT_CYCLES watchdog on the ISSUE
//   state that aborts into a sticky ERR state until reset.
module aes_stream_ctrl
  import aes_stream_pkg::*;
#(
  parameter int unsigned WDT_CYCLES = 4096
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [AES_BLK_W-1:0] s_data,
  input  logic                 s_first,
  input  logic [AES_BLK_W-1:0] s_key,
  input  logic                 s_enc_dec,
  input  logic                 s_mode,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [AES_BLK_W-1:0] m_data,
  output logic                 m_first,
  output logic                 core_init,
  output logic                 core_next,
  output logic                 core_enc_dec,
  output logic                 core_mode,
  output logic [AES_BLK_W-1:0] core_key,
  output logic [AES_BLK_W-1:0] core_block_in,
  input  logic [AES_BLK_W-1:0] core_block_out,
  input  logic                 core_valid,
  output logic                 busy,
  output logic [AES_CNT_W-1:0] blk_cnt,
  output logic                 err
);

  state_t state;
  logic   key_loaded;

  // Gated by rst so the upstream never sees ready while reset is held.
  assign s_ready = (state == IDLE) && !rst;
  assign busy    = (state != IDLE);

`ifdef AES_STREAM_CTRL_WDT_EN
  logic wdt_expired;

  aes_stream_wdt #(
    .WDT_CYCLES(WDT_CYCLES)
  ) u_wdt (
    .clk    (clk),
    .rst    (rst),
    .run    (state == ISSUE),
    .expired(wdt_expired)
  );
`else
  logic unused_wdt;
  assign unused_wdt = (WDT_CYCLES == 0);
  assign err        = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      key_loaded    <= 1'b0;
      core_init     <= 1'b0;
      core_next     <= 1'b0;
      m_valid       <= 1'b0;
      m_first       <= 1'b0;
      m_data        <= '0;
      core_block_in <= '0;
      core_key      <= '0;
      core_enc_dec  <= 1'b0;
      core_mode     <= 1'b0;
      blk_cnt       <= '0;
`ifdef AES_STREAM_CTRL_WDT_EN
      err           <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (s_valid) begin
            core_block_in <= s_data;
            state         <= ISSUE;
            // A fresh key schedule is needed on message start and after any
            // reset/abort; otherwise the core keeps chaining on its last key.
            if (s_first || !key_loaded) begin
              core_init    <= 1'b1;
              core_key     <= s_key;
              core_enc_dec <= s_enc_dec;
              core_mode    <= s_mode;
              blk_cnt      <= '0;
              key_loaded   <= 1'b1;
            end else begin
              core_next    <= 1'b1;
            end
          end
        end

        ISSUE: begin
          if (core_valid) begin
            m_data    <= core_block_out;
            m_first   <= core_init;
            m_valid   <= 1'b1;
            core_init <= 1'b0;
            core_next <= 1'b0;
            state     <= OUT;
          end
`ifdef AES_STREAM_CTRL_WDT_EN
          else if (wdt_expired) begin
            core_init  <= 1'b0;
            core_next  <= 1'b0;
            key_loaded <= 1'b0;
            err        <= 1'b1;
            state      <= ERR;
          end
`endif
        end

        OUT: begin
          if (m_ready) begin
            m_valid <= 1'b0;
            blk_cnt <= blk_cnt + 16'd1;
            state   <= IDLE;
          end
        end

`ifdef AES_STREAM_CTRL_WDT_EN
        ERR: begin
          state <= ERR;
        end
`endif

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_stream_ctrl.sv
// tb_aes_stream_ctrl -- randomized self-checking bench for aes_stream_ctrl.
// The bench plays the AES core (toy invertible cipher, with the FIPS-197
// AES-128 example vector answered exactly) and predicts every result from a
// message-level model of key latching, CBC chaining (IV=1) and block counting.
// Define AES_STREAM_CTRL_WDT_EN to also exercise the watchdog abort.
module tb_aes_stream_ctrl;

  localparam logic [127:0] KAT_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] KAT_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KAT_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] IV      = 128'd1;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         s_valid = 1'b0;
  logic         s_ready;
  logic [127:0] s_data = '0;
  logic         s_first = 1'b0;
  logic [127:0] s_key = '0;
  logic         s_enc_dec = 1'b0;
  logic         s_mode = 1'b0;
  logic         m_valid;
  logic         m_ready = 1'b0;
  logic [127:0] m_data;
  logic         m_first;
  logic         core_init;
  logic         core_next;
  logic         core_enc_dec;
  logic         core_mode;
  logic [127:0] core_key;
  logic [127:0] core_block_in;
  logic [127:0] core_block_out = '0;
  logic         core_valid;
  logic         busy;
  logic [15:0]  blk_cnt;
  logic         err;

  always #5 clk = ~clk;

  aes_stream_ctrl #(
    .WDT_CYCLES(16)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .s_data        (s_data),
    .s_first       (s_first),
    .s_key         (s_key),
    .s_enc_dec     (s_enc_dec),
    .s_mode        (s_mode),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .m_data        (m_data),
    .m_first       (m_first),
    .core_init     (core_init),
    .core_next     (core_next),
    .core_enc_dec  (core_enc_dec),
    .core_mode     (core_mode),
    .core_key      (core_key),
    .core_block_in (core_block_in),
    .core_block_out(core_block_out),
    .core_valid    (core_valid),
    .busy          (busy),
    .blk_cnt       (blk_cnt),
    .err           (err)
  );

  int unsigned checks   = 0;
  int unsigned failures = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Toy block cipher: invertible, and exact on the FIPS-197 example.
  function automatic logic [127:0] cipher(input logic [127:0] key, input logic enc,
                                          input logic [127:0] x);
    logic [127:0] t;
    if (key == KAT_KEY && enc && x == KAT_PT) return KAT_CT;
    if (key == KAT_KEY && !enc && x == KAT_CT) return KAT_PT;
    if (enc) begin
      t = x ^ key;
      return {t[120:0], t[127:121]};
    end
    t = {x[6:0], x[127:7]};
    return t ^ key;
  endfunction

  // ---------------- core stand-in ----------------
  logic         resp_valid  = 1'b0;
  logic         stray_valid = 1'b0;
  logic         core_en     = 1'b1;
  logic [127:0] chain       = '0;
  int           lat         = -1;
  int unsigned  cyc         = 0;
  int unsigned  resp_cyc    = 0;

  assign core_valid = resp_valid | stray_valid;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst) begin
      resp_valid = 1'b0;
      lat = -1;
    end else if (resp_valid) begin
      resp_valid = 1'b0;
    end else if ((core_init || core_next) && core_en) begin
      if (lat < 0) lat = int'($urandom_range(3, 0));
      if (lat == 0) begin
        if (core_init) chain = IV;
        if (!core_mode) begin
          core_block_out = cipher(core_key, core_enc_dec, core_block_in);
        end else if (core_enc_dec) begin
          core_block_out = cipher(core_key, 1'b1, core_block_in ^ chain);
          chain = core_block_out;
        end else begin
          core_block_out = cipher(core_key, 1'b0, core_block_in) ^ chain;
          chain = core_block_in;
        end
        resp_valid = 1'b1;
        resp_cyc   = cyc;
        lat        = -1;
      end else begin
        lat--;
      end
    end
  end

  // ---------------- message-level reference ----------------
  logic         ref_have_key = 1'b0;
  logic [127:0] ref_key = '0;
  logic [127:0] ref_prev = '0;
  logic         ref_enc = 1'b0;
  logic         ref_cbc = 1'b0;
  int unsigned  ref_cnt = 0;
  logic         exp_init;
  logic [127:0] exp_out;
  logic [15:0]  exp_cnt;

  task automatic ref_step(input logic first, input logic [127:0] key, input logic enc,
                          input logic cbc, input logic [127:0] data);
    exp_init = first || !ref_have_key;
    if (exp_init) begin
      ref_have_key = 1'b1;
      ref_key  = key;
      ref_enc  = enc;
      ref_cbc  = cbc;
      ref_prev = IV;
      ref_cnt  = 0;
    end
    if (!ref_cbc) begin
      exp_out = cipher(ref_key, ref_enc, data);
    end else if (ref_enc) begin
      exp_out  = cipher(ref_key, 1'b1, data ^ ref_prev);
      ref_prev = exp_out;
    end else begin
      exp_out  = cipher(ref_key, 1'b0, data) ^ ref_prev;
      ref_prev = data;
    end
    ref_cnt = (ref_cnt + 1) % 65536;
    exp_cnt = ref_cnt[15:0];
  endtask

  // ---------------- stimulus ----------------
  // Called and returns just after a rising edge.
  task automatic xfer(input logic first, input logic [127:0] key, input logic enc,
                      input logic cbc, input logic [127:0] data);
    int unsigned n;
    n = 0;
    s_first = first; s_key = key; s_enc_dec = enc; s_mode = cbc; s_data = data;
    s_valid = 1'b1;
    while (!s_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("s_ready_wait", 128'(s_ready), 128'd1);
    @(posedge clk); #1;
    s_valid   = 1'b0;
    s_first   = 1'($urandom_range(1, 0));
    s_key     = rnd128();
    s_enc_dec = 1'($urandom_range(1, 0));
    s_mode    = 1'($urandom_range(1, 0));
    s_data    = rnd128();
  endtask

  task automatic run_block(input logic first, input logic [127:0] key, input logic enc,
                           input logic cbc, input logic [127:0] data,
                           input int unsigned hold, input logic early);
    int unsigned n;
    n = 0;
    ref_step(first, key, enc, cbc, data);
    m_ready = early;
    xfer(first, key, enc, cbc, data);
    check("req_init", 128'(core_init), 128'(exp_init));
    check("req_next", 128'(core_next), 128'(!exp_init));
    check("blk_in", core_block_in, data);
    check("busy_issue", 128'(busy), 128'd1);
    while (!m_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
      if (!m_valid) begin
        check("hold_init", 128'(core_init), 128'(exp_init));
        check("hold_next", 128'(core_next), 128'(!exp_init));
        check("hold_blk", core_block_in, data);
        check("s_ready_busy", 128'(s_ready), 128'd0);
      end
    end
    check("m_valid_seen", 128'(m_valid), 128'd1);
    check("m_latency", 128'(cyc), 128'(resp_cyc + 1));
    check("m_data", m_data, exp_out);
    check("m_first", 128'(m_first), 128'(exp_init));
    check("req_drop", 128'({core_init, core_next}), 128'd0);
    check("s_ready_out", 128'(s_ready), 128'd0);
    if (!early) begin
      repeat (hold) begin
        @(posedge clk); #1;
        check("m_hold_valid", 128'(m_valid), 128'd1);
        check("m_hold_data", m_data, exp_out);
      end
    end
    m_ready = 1'b1;
    @(posedge clk); #1;
    m_ready = 1'b0;
    check("m_done", 128'(m_valid), 128'd0);
    check("s_ready_next", 128'(s_ready), 128'd1);
    check("busy_idle", 128'(busy), 128'd0);
    check("blk_cnt", 128'(blk_cnt), 128'(exp_cnt));
    check("err_quiet", 128'(err), 128'd0);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_init"}, 128'(core_init), 128'd0);
    check({tag, "_next"}, 128'(core_next), 128'd0);
    check({tag, "_mvalid"}, 128'(m_valid), 128'd0);
    check({tag, "_mfirst"}, 128'(m_first), 128'd0);
    check({tag, "_mdata"}, m_data, 128'd0);
    check({tag, "_blkin"}, core_block_in, 128'd0);
    check({tag, "_key"}, core_key, 128'd0);
    check({tag, "_cfg"}, 128'({core_enc_dec, core_mode}), 128'd0);
    check({tag, "_cnt"}, 128'(blk_cnt), 128'd0);
    check({tag, "_err"}, 128'(err), 128'd0);
    check({tag, "_sready"}, 128'(s_ready), 128'd0);
    check({tag, "_busy"}, 128'(busy), 128'd0);
  endtask

  task automatic reset_ref();
    ref_have_key = 1'b0;
    ref_cnt = 0;
  endtask

  initial begin
    #400000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "run aborted");
  end

  initial begin
    logic [127:0] d;
    logic         f;

    // Reset state
    #2 rst = 1'b1;
    #1 check_cleared("rst");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // FIPS-197 ECB encrypt
    run_block(1'b1, KAT_KEY, 1'b1, 1'b0, KAT_PT, 2, 1'b0);
    check("kat_enc", m_data, KAT_CT);
    check("kat_cnt", 128'(blk_cnt), 128'd1);

    // CBC encrypt, 3 blocks, m_ready held high throughout
    d = rnd128();
    run_block(1'b1, d, 1'b1, 1'b1, rnd128(), 0, 1'b1);
    run_block(1'b0, rnd128(), 1'b0, 1'b0, rnd128(), 0, 1'b1);
    run_block(1'b0, rnd128(), 1'b0, 1'b0, rnd128(), 0, 1'b1);
    check("cbc_cnt", 128'(blk_cnt), 128'd3);

    // ECB decrypt with 10 cycles of back-pressure
    run_block(1'b1, KAT_KEY, 1'b0, 1'b0, KAT_CT, 10, 1'b0);
    check("kat_dec", m_data, KAT_PT);

    // core_valid while idle is ignored
    d = m_data;
    core_block_out = rnd128();
    stray_valid = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    stray_valid = 1'b0;
    check("stray_mvalid", 128'(m_valid), 128'd0);
    check("stray_busy", 128'(busy), 128'd0);
    check("stray_mdata", m_data, d);

    // Random traffic: mixed messages, modes, keys, back-pressure
    for (int i = 0; i < 60; i++) begin
      f = (i == 0) || ($urandom_range(3, 0) == 0);
      run_block(f, rnd128(), 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
                rnd128(), $urandom_range(4, 0), 1'($urandom_range(1, 0)));
    end

    // Counter wrap: preload as if 65534 blocks had completed
    dut.blk_cnt = 16'hFFFE;
    ref_cnt = 65534;
    run_block(1'b0, rnd128(), 1'b1, 1'b0, rnd128(), 1, 1'b0);
    check("cnt_ffff", 128'(blk_cnt), 128'hFFFF);
    run_block(1'b0, rnd128(), 1'b1, 1'b0, rnd128(), 0, 1'b1);
    check("cnt_wrap", 128'(blk_cnt), 128'h0000);

    // Reset in the middle of ISSUE; next block must re-init
    core_en = 1'b0;
    xfer(1'b1, rnd128(), 1'b1, 1'b1, rnd128());
    @(posedge clk); #1;
    check("mid_issue_busy", 128'(busy), 128'd1);
    #2 rst = 1'b1;
    #1 check_cleared("mid_rst");
    @(negedge clk);
    rst = 1'b0;
    core_en = 1'b1;
    reset_ref();
    @(posedge clk); #1;
    run_block(1'b0, rnd128(), 1'b1, 1'b0, rnd128(), 1, 1'b0);

`ifdef AES_STREAM_CTRL_WDT_EN
    // Watchdog: core never answers
    core_en = 1'b0;
    xfer(1'b1, rnd128(), 1'b1, 1'b0, rnd128());
    for (int i = 1; i < 16; i++) begin
      @(posedge clk); #1;
      check("wdt_pending", 128'(err), 128'd0);
    end
    @(posedge clk); #1;
    check("wdt_err", 128'(err), 128'd1);
    check("wdt_init", 128'({core_init, core_next}), 128'd0);
    s_valid = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      check("wdt_sready", 128'(s_ready), 128'd0);
      check("wdt_busy", 128'(busy), 128'd1);
      check("wdt_sticky", 128'(err), 128'd1);
    end
    s_valid = 1'b0;
    #2 rst = 1'b1;
    #1 check_cleared("wdt_rst");
    @(negedge clk);
    rst = 1'b0;
    core_en = 1'b1;
    reset_ref();
    @(posedge clk); #1;
    run_block(1'b0, rnd128(), 1'b0, 1'b1, rnd128(), 0, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
